// File: rtl/rob_defs.sv
// rtl/rob_defs.sv - shared ROB/PRF types for the writeback arbiter
package rob_defs;

  localparam int ROB_ID_W  = 6;
  localparam int PREG_W    = 7;
  localparam int WB_MAX_CH = 8;

  typedef logic [ROB_ID_W-1:0] t_rob_id;

  typedef struct packed {
    t_rob_id    robid;
    logic       exc;
    logic [4:0] cause;
  } t_rob_result;

  typedef struct packed {
    logic [PREG_W-1:0] preg;
    logic [31:0]       data;
  } t_prf_wr_pkt;

  typedef struct packed {
    logic    valid;
    t_rob_id robid;
  } t_nuke_pkt;

  typedef struct packed {
    t_rob_result result;
    logic        wr_en;
    t_prf_wr_pkt wr_pkt;
  } t_wb_ent;

  // Distance from the ROB head; unsigned wrap makes older entries smaller.
  function automatic t_rob_id rob_age(input t_rob_id id, input t_rob_id oldest);
    return id - oldest;
  endfunction

endpackage

// File: rtl/wb_arb_q.sv
// rtl/wb_arb_q.sv - single-channel writeback result queue
// Ready is registered from the next count so it never depends on the same-cycle dequeue.
module wb_arb_q
  import rob_defs::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    flush,
  input  logic    enq,
  input  t_wb_ent enq_ent,
  input  logic    deq,
  output logic    ready,
  output logic    not_empty,
  output t_wb_ent head_ent
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ready_q, ready_d;
  t_wb_ent          mem_q [DEPTH];
  t_wb_ent          mem_d [DEPTH];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    mem_d   = mem_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq) begin
        mem_d[tail_q] = enq_ent;
        tail_d        = ptr_inc(tail_q);
      end
      if (deq) head_d = ptr_inc(head_q);
      if (enq && !deq)      count_d = count_q + 1'b1;
      else if (!enq && deq) count_d = count_q - 1'b1;
    end
    ready_d = count_d < CNT_W'(DEPTH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ready_q <= 1'b1;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ready_q <= ready_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign ready     = ready_q;
  assign not_empty = (count_q != '0);
  assign head_ent  = mem_q[head_q];

endmodule

// File: rtl/wb_arb.sv
// rtl/wb_arb.sv - writeback arbiter merging NUM_CH result queues onto the ROB/PRF ports
// WB_ARB_AGE_PRIO_EN selects oldest-robid-first grants instead of round-robin.
module wb_arb
  import rob_defs::*;
#(
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  t_nuke_pkt   nuke_rb1,
  input  t_rob_id     oldest_robid,
  input  logic        src_valid_ex1  [NUM_CH],
  output logic        src_ready_ex1  [NUM_CH],
  input  t_rob_result src_result_ex1 [NUM_CH],
  input  logic        src_wr_en_ex1  [NUM_CH],
  input  t_prf_wr_pkt src_wr_pkt_ex1 [NUM_CH],
  output logic        ro_valid_rb0,
  output t_rob_result ro_result_rb0,
  output logic        iprf_wr_en_ro0,
  output t_prf_wr_pkt iprf_wr_pkt_ro0
);

  localparam int GNT_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic             q_ready    [NUM_CH];
  logic             q_nonempty [NUM_CH];
  logic             q_enq      [NUM_CH];
  logic             q_deq      [NUM_CH];
  t_wb_ent          q_in       [NUM_CH];
  t_wb_ent          q_head     [NUM_CH];
  logic             gnt_vld;
  logic [GNT_W-1:0] gnt_idx;
  t_wb_ent          gnt_ent;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign q_in[c]          = '{result: src_result_ex1[c], wr_en: src_wr_en_ex1[c],
                                wr_pkt: src_wr_pkt_ex1[c]};
    assign q_enq[c]         = src_valid_ex1[c] && q_ready[c] && !nuke_rb1.valid;
    assign q_deq[c]         = gnt_vld && (gnt_idx == GNT_W'(c));
    assign src_ready_ex1[c] = q_ready[c];

    wb_arb_q #(.DEPTH(DEPTH)) u_q (
      .clk       (clk),
      .reset     (reset),
      .flush     (nuke_rb1.valid),
      .enq       (q_enq[c]),
      .enq_ent   (q_in[c]),
      .deq       (q_deq[c]),
      .ready     (q_ready[c]),
      .not_empty (q_nonempty[c]),
      .head_ent  (q_head[c])
    );
  end

`ifdef WB_ARB_AGE_PRIO_EN
  t_rob_id best_age;
  logic    unused_ok;

  // Strict less-than while scanning upward leaves ties with the lowest channel.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    best_age = '1;
    for (int c = 0; c < NUM_CH; c++) begin
      if (q_nonempty[c] &&
          (!gnt_vld || rob_age(q_head[c].result.robid, oldest_robid) < best_age)) begin
        gnt_vld  = 1'b1;
        gnt_idx  = GNT_W'(c);
        best_age = rob_age(q_head[c].result.robid, oldest_robid);
      end
    end
    if (nuke_rb1.valid) gnt_vld = 1'b0;
  end

  assign unused_ok = ^nuke_rb1.robid;
`else
  logic [GNT_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [GNT_W-1:0] rr_idx;
  logic             unused_ok;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    rr_idx  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      rr_idx = GNT_W'((int'(rr_ptr_q) + i) % NUM_CH);
      if (!gnt_vld && q_nonempty[rr_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = rr_idx;
      end
    end
    if (nuke_rb1.valid) gnt_vld = 1'b0;
    rr_ptr_d = rr_ptr_q;
    if (gnt_vld) rr_ptr_d = (gnt_idx == GNT_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end

  assign unused_ok = ^{oldest_robid, nuke_rb1.robid};
`endif

  logic        ro_valid_q, ro_valid_d;
  t_rob_result ro_result_q, ro_result_d;
  logic        iprf_wr_en_q, iprf_wr_en_d;
  t_prf_wr_pkt iprf_wr_pkt_q, iprf_wr_pkt_d;

  assign gnt_ent = q_head[gnt_idx];

  always_comb begin
    ro_valid_d    = gnt_vld;
    iprf_wr_en_d  = gnt_vld && gnt_ent.wr_en;
    ro_result_d   = ro_result_q;
    iprf_wr_pkt_d = iprf_wr_pkt_q;
    if (gnt_vld) begin
      ro_result_d   = gnt_ent.result;
      iprf_wr_pkt_d = gnt_ent.wr_pkt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ro_valid_q    <= 1'b0;
      ro_result_q   <= '0;
      iprf_wr_en_q  <= 1'b0;
      iprf_wr_pkt_q <= '0;
    end else begin
      ro_valid_q    <= ro_valid_d;
      ro_result_q   <= ro_result_d;
      iprf_wr_en_q  <= iprf_wr_en_d;
      iprf_wr_pkt_q <= iprf_wr_pkt_d;
    end
  end

  assign ro_valid_rb0    = ro_valid_q;
  assign ro_result_rb0   = ro_result_q;
  assign iprf_wr_en_ro0  = iprf_wr_en_q;
  assign iprf_wr_pkt_ro0 = iprf_wr_pkt_q;

endmodule

// File: tb/tb_wb_arb.sv
// tb/tb_wb_arb.sv - directed self-checking bench for wb_arb (NUM_CH=2, DEPTH=4)
module tb_wb_arb;
  import rob_defs::*;

  localparam int NUM_CH = 2;
  localparam int DEPTH  = 4;

  logic        clk = 1'b0;
  logic        reset;
  t_nuke_pkt   nuke;
  t_rob_id     oldest;
  logic        sv   [NUM_CH];
  logic        sr   [NUM_CH];
  t_rob_result sres [NUM_CH];
  logic        swe  [NUM_CH];
  t_prf_wr_pkt spkt [NUM_CH];
  logic        ro_valid;
  t_rob_result ro_result;
  logic        wr_en;
  t_prf_wr_pkt wr_pkt;

  int n_checks = 0;
  int n_pass   = 0;

  int   idx [NUM_CH];
  logic acc [NUM_CH];
  int   got_q [$];
  bit   saw_full1;
  int   exp_id;

  always #5 clk = ~clk;

  wb_arb #(.NUM_CH(NUM_CH), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .nuke_rb1        (nuke),
    .oldest_robid    (oldest),
    .src_valid_ex1   (sv),
    .src_ready_ex1   (sr),
    .src_result_ex1  (sres),
    .src_wr_en_ex1   (swe),
    .src_wr_pkt_ex1  (spkt),
    .ro_valid_rb0    (ro_valid),
    .ro_result_rb0   (ro_result),
    .iprf_wr_en_ro0  (wr_en),
    .iprf_wr_pkt_ro0 (wr_pkt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    for (int c = 0; c < NUM_CH; c++) begin
      sv[c]   = 1'b0;
      sres[c] = '0;
      swe[c]  = 1'b0;
      spkt[c] = '0;
    end
    nuke = '0;
  endtask

  task automatic offer(input int c, input int robid, input logic we);
    sv[c]   = 1'b1;
    sres[c] = '{robid: t_rob_id'(robid), exc: 1'b0, cause: 5'd0};
    swe[c]  = we;
    spkt[c] = '{preg: 7'(robid + 1), data: 32'(robid * 3)};
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    idle_inputs();
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    oldest = '0;
    reset  = 1'b1;
    idle_inputs();

    // reset state
    cyc();
    cyc();
    check("rst_ro_valid", 64'(ro_valid), 64'd0);
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_result", 64'(ro_result), 64'd0);
    check("rst_pkt", 64'(wr_pkt), 64'd0);
    reset = 1'b0;
    cyc();
    check("rst_ready0", 64'(sr[0]), 64'd1);
    check("rst_ready1", 64'(sr[1]), 64'd1);

    // single result, two-cycle latency
    offer(0, 5, 1'b1);
    cyc();
    sv[0] = 1'b0;
    check("lat_n1_valid", 64'(ro_valid), 64'd0);
    cyc();
    check("lat_n2_valid", 64'(ro_valid), 64'd1);
    check("lat_n2_robid", 64'(ro_result.robid), 64'd5);
    check("lat_n2_wr_en", 64'(wr_en), 64'd1);
    check("lat_n2_preg", 64'(wr_pkt.preg), 64'd6);
    check("lat_n2_data", 64'(wr_pkt.data), 64'd15);
    cyc();
    check("lat_n3_valid", 64'(ro_valid), 64'd0);
    offer(1, 9, 1'b0);
    cyc();
    sv[1] = 1'b0;
    cyc();
    check("noprf_valid", 64'(ro_valid), 64'd1);
    check("noprf_robid", 64'(ro_result.robid), 64'd9);
    check("noprf_wr_en", 64'(wr_en), 64'd0);
    cyc();

`ifndef WB_ARB_AGE_PRIO_EN
    // both channels streaming: strict alternation, ch1 backs up to full
    reset_dut();
    idx[0]    = 0;
    idx[1]    = 0;
    saw_full1 = 1'b0;
    for (int cy = 0; cy < 60; cy++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (idx[c] < 8) offer(c, (c == 0 ? 10 : 20) + idx[c], 1'b1);
        else sv[c] = 1'b0;
        acc[c] = sv[c] && sr[c];
      end
      if (!sr[1]) saw_full1 = 1'b1;
      cyc();
      for (int c = 0; c < NUM_CH; c++) if (acc[c]) idx[c]++;
      if (ro_valid) got_q.push_back(int'(ro_result.robid));
    end
    check("rr_count", 64'(got_q.size()), 64'd16);
    for (int k = 0; k < 16 && k < got_q.size(); k++) begin
      exp_id = (k % 2 == 0) ? 10 + k / 2 : 20 + k / 2;
      check($sformatf("rr_order[%0d]", k), 64'(got_q[k]), 64'(exp_id));
    end
    check("rr_ch1_full", 64'(saw_full1), 64'd1);
`endif

    // nuke with entries queued in both channels
    offer(0, 40, 1'b1);
    offer(1, 50, 1'b1);
    cyc();
    offer(0, 41, 1'b1);
    offer(1, 51, 1'b1);
    cyc();
    check("nk_out0", 64'(ro_result.robid), 64'd40);
    offer(0, 42, 1'b1);
    sv[1] = 1'b0;
    cyc();
`ifdef WB_ARB_AGE_PRIO_EN
    check("nk_out1", 64'(ro_result.robid), 64'd41);
`else
    check("nk_out1", 64'(ro_result.robid), 64'd50);
`endif
    nuke.valid = 1'b1;
    offer(0, 33, 1'b1);
    cyc();
    idle_inputs();
    check("nk_valid", 64'(ro_valid), 64'd0);
    check("nk_ready0", 64'(sr[0]), 64'd1);
    check("nk_ready1", 64'(sr[1]), 64'd1);
    cyc();
    check("nk_stale1", 64'(ro_valid), 64'd0);
    cyc();
    check("nk_stale2", 64'(ro_valid), 64'd0);
    offer(1, 60, 1'b1);
    cyc();
    sv[1] = 1'b0;
    check("nk_inj_n1", 64'(ro_valid), 64'd0);
    cyc();
    check("nk_inj_n2", 64'(ro_valid), 64'd1);
    check("nk_inj_id", 64'(ro_result.robid), 64'd60);
    cyc();

`ifdef WB_ARB_AGE_PRIO_EN
    // age priority across the robid wrap
    reset_dut();
    oldest = t_rob_id'(30);
    offer(0, 2, 1'b1);
    offer(1, 31, 1'b1);
    cyc();
    idle_inputs();
    cyc();
    check("age_first", 64'(ro_result.robid), 64'd31);
    cyc();
    check("age_second", 64'(ro_result.robid), 64'd2);
    check("age_second_v", 64'(ro_valid), 64'd1);
    cyc();
    oldest = '0;
`endif

    // reset mid-traffic
    offer(0, 70, 1'b1);
    offer(1, 20, 1'b1);
    cyc();
    offer(0, 71, 1'b1);
    sv[1] = 1'b0;
    cyc();
    reset = 1'b1;
    idle_inputs();
    cyc();
    check("mid_rst_valid", 64'(ro_valid), 64'd0);
    check("mid_rst_wr_en", 64'(wr_en), 64'd0);
    check("mid_rst_result", 64'(ro_result), 64'd0);
    check("mid_rst_pkt", 64'(wr_pkt), 64'd0);
    check("mid_rst_ready0", 64'(sr[0]), 64'd1);
    check("mid_rst_ready1", 64'(sr[1]), 64'd1);
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      check($sformatf("mid_rst_stale[%0d]", k), 64'(ro_valid), 64'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_arb.md
# wb_arb

Parametrised writeback arbiter merging result streams from `NUM_CH` execution pipes onto the single ROB result port and the single integer PRF write port. It replaces the point-to-point `exe`→`rob` hookup so the `mem` pipe and future pipes can retire results. Each channel has a small queue. A round-robin or age-based arbiter drains one entry per cycle into a registered output stage. A nuke flushes all queued results.

## Interface
Parameters:
- `NUM_CH`, 2, number of producing pipes, 1..8.
- `DEPTH`, 4, per-channel queue entries, ≥2; need not be a power of two.

Ports:
- `clk`  in  1  core clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `nuke_rb1`  in  `t_nuke_pkt`  pipeline flush; only `.valid` is used.
- `oldest_robid`  in  `t_rob_id`  ROB head; used only in age mode.
- `src_valid_ex1[NUM_CH]`  in  1  channel offers a result.
- `src_ready_ex1[NUM_CH]`  out  1  channel queue can accept.
- `src_result_ex1[NUM_CH]`  in  `t_rob_result`  ROB completion payload.
- `src_wr_en_ex1[NUM_CH]`  in  1  result also writes the PRF.
- `src_wr_pkt_ex1[NUM_CH]`  in  `t_prf_wr_pkt`  PRF write payload.
- `ro_valid_rb0`  out  1  ROB completion valid.
- `ro_result_rb0`  out  `t_rob_result`  ROB completion payload.
- `iprf_wr_en_ro0`  out  1  PRF write enable.
- `iprf_wr_pkt_ro0`  out  `t_prf_wr_pkt`  PRF write payload.

## Operation
- Enqueue: when `src_valid_ex1[c] && src_ready_ex1[c]`, store {result, wr_en, wr_pkt} at the tail of queue c.
  - Sources hold valid and payload until accepted.
- `src_ready_ex1[c]` = count[c] < DEPTH, taken from registered count only.
  - A full queue does not accept in the same cycle it dequeues.
- Pointers: head/tail are `$clog2(DEPTH)` bits and wrap explicitly at DEPTH-1 → 0.
  - count is `$clog2(DEPTH+1)` bits.
  - Simultaneous enqueue and dequeue leaves count unchanged.
- Arbitration: each cycle, among channels with count > 0, grant one and dequeue its head.
  - Default round-robin: search starts at `rr_ptr`.
  - After a grant to channel g, `rr_ptr` ← (g+1) mod NUM_CH.
  - `rr_ptr` is unchanged on idle cycles.
- Output stage: the granted head is registered into the `ro_*`/`iprf_*` outputs.
  - `iprf_wr_en_ro0` = `ro_valid_rb0 && stored wr_en`.
  - With no grant, both valids are 0 next cycle.
- The ROB and PRF always accept; there is no backpressure on the output.
- Nuke: in any cycle with `nuke_rb1.valid`:
  - all counts and pointers clear;
  - inputs offered in that cycle are dropped;
  - no grant occurs;
  - output valids are 0 the next cycle.
  - `rr_ptr` is retained.
- Reset: counts, pointers and `rr_ptr` are 0; `ro_valid_rb0`=0; `iprf_wr_en_ro0`=0; payload outputs are 0; all `src_ready_ex1` are 1 after reset deasserts.

## Timing
- Accept in cycle N → entry is at the queue head in N+1 → output valid in N+2 if granted in N+1. Minimum latency is 2 cycles.
- Throughput is 1 result/cycle aggregate.
- Per channel, sustained 1/cycle is possible when DEPTH≥2 and the channel is uncontested.
- Worst-case wait for a non-empty channel under round-robin is NUM_CH-1 grants.
- Ready updates one cycle after a count change (registered).
- Nuke in cycle N: an output registered at the end of N-1 is still presented in N. It is the ROB's job to ignore it.

## Configuration
- `WB_ARB_AGE_PRIO_EN`
  - Defined: grant the non-empty head with the smallest `(result.robid - oldest_robid)`, computed as an unsigned `t_rob_id`-width subtraction that wraps naturally. Ties go to the lowest channel index. `rr_ptr` is unused.
  - Undefined: pure round-robin as above; `oldest_robid` is ignored.

## Structure
- Shared package (`rob_defs`): `t_wb_ent` {t_rob_result result; logic wr_en; t_prf_wr_pkt wr_pkt;} and a `WB_MAX_CH` constant.
- One sub-module, `wb_arb_q`: single-channel queue holding count, head/tail, storage and registered ready, with enq/deq/flush inputs.
  - `wb_arb` instantiates NUM_CH copies plus the arbiter and the output register.

## Test plan
- Single channel (NUM_CH=2): inject robid 5 on ch0 at cycle 10 → `ro_valid_rb0`=1 with robid 5 at cycle 12; `iprf_wr_en_ro0` mirrors wr_en.
- Both channels valid every cycle for 8 cycles → outputs alternate ch0,ch1,ch0,…; no entry is lost or duplicated (scoreboard).
- Hold ch1 valid while downstream starves it (ch0 continuously granted under age mode) until count=DEPTH=4 → `src_ready_ex1[1]`=0 next cycle; the source holds and the 5th result is accepted only after a dequeue.
- Fill ch0 with 3 entries, ch1 with 2, assert `nuke_rb1.valid` → next cycle all ready=1, no output valid; a later inject emerges after exactly 2 cycles.
- `WB_ARB_AGE_PRIO_EN`, oldest_robid=30 (6-bit robid): ch0 head robid 2, ch1 head robid 31 → ch1 granted first (age 1 vs 36).
- Reset asserted mid-traffic with queues non-empty → next cycle all outputs 0, readies 1, no stale entry emitted afterward.
